// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch path.
package fetch_pkg;

   localparam int unsigned FQ_DEPTH_DEFAULT = 4;
   localparam logic [31:0] NOP_INST = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundle between the PC/SRAM/decode side (master) and the fetch queue (slave).
interface inst_fetch_queue_if;

   logic [13:0] pc;
   logic [31:0] pc_reg;
   logic        flush;
   logic [31:0] im_dout;
   logic        dec_ready;
   logic        im_cs;
   logic [13:0] im_addr;
   logic        fq_valid;
   logic [31:0] fq_inst;
   logic [31:0] fq_pc;
   logic        fetch_stall;

   modport master (
      output pc, pc_reg, flush, im_dout, dec_ready,
      input  im_cs, im_addr, fq_valid, fq_inst, fq_pc, fetch_stall
   );

   modport slave (
      input  pc, pc_reg, flush, im_dout, dec_ready,
      output im_cs, im_addr, fq_valid, fq_inst, fq_pc, fetch_stall
   );

endinterface

// File: rtl/fq_fifo.sv
// Circular buffer of {pc, inst} entries with synchronous clear and a
// combinational head that reads as a NOP at PC 0 when empty.
module fq_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clear,
   input  logic      push,
   input  fq_entry_t push_entry,
   input  logic      pop,
   output logic [PW:0] count,
   output logic      head_valid,
   output fq_entry_t head
);

   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   fq_entry_t        mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic             do_pop, do_push;

   // Pop on empty is ignored; a push into a full queue only lands if a pop frees a slot.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != DEPTH_C) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + (PW+1)'(1);
         else if (do_pop && !do_push) count <= count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_entry;
   end

   assign head_valid = (count != '0);
   assign head       = head_valid ? mem[rd_ptr] : '{pc: 32'd0, inst: NOP_INST};

endmodule

// File: rtl/inst_fetch_queue.sv
// Issues SRAM reads from the PC, tracks the single in-flight read, and queues
// returned instructions toward decode; holds the PC when the queue may overflow.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   inst_fetch_queue_if.slave  bus
);

   localparam int unsigned PW          = $clog2(DEPTH);
   localparam logic [PW+1:0] DEPTH_W   = (PW+2)'(DEPTH);

   logic          if_v;
   logic          kill;
   logic [31:0]   if_pc;
   logic [PW:0]   count;
   logic [PW+1:0] occupancy;
   logic          stall;
   logic          issue;
   logic          push;
   logic          head_valid;
   fq_entry_t     push_entry;
   fq_entry_t     head;

   // Counts the in-flight read as occupied; a same-cycle pop is ignored on purpose.
   assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, if_v};
   assign stall     = (occupancy >= DEPTH_W);
   assign issue     = !bus.flush && !stall;

   assign push       = if_v && !kill && !bus.flush;
   assign push_entry = '{pc: if_pc, inst: bus.im_dout};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_v  <= 1'b0;
         kill  <= 1'b0;
         if_pc <= 32'd0;
      end else begin
         if_v <= issue;
         kill <= bus.flush;
         if (issue) if_pc <= bus.pc_reg;
      end
   end

   fq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.flush),
      .push       (push),
      .push_entry (push_entry),
      .pop        (bus.dec_ready),
      .count      (count),
      .head_valid (head_valid),
      .head       (head)
   );

   assign bus.im_cs       = issue;
   assign bus.im_addr     = bus.pc;
   assign bus.fetch_stall = stall;
   assign bus.fq_valid    = head_valid;
   assign bus.fq_inst     = head.inst;
   assign bus.fq_pc       = head.pc;

endmodule
